// File: rtl/mux_rr_pkg.sv
// Shared helpers and defaults for the round-robin stream mux.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mux_rr_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = 8;

  // Index width for n channels, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_rr_stream_arbiter.sv
// Combinational N-way arbiter: cyclic priority from ptr, or a forced index.
// Latency: zero (purely combinational).
// Backpressure: none here; the caller gates the grant with its own slot-free term.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             force_en,
  input  logic [SEL_W-1:0] force_sel,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] grant_idx,
  output logic             any_grant
);

  // Pick at most one requester: the forced index when forcing (none if out of
  // range or idle), otherwise the first requester at or after ptr, wrapping.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    if (force_en) begin
      for (int i = 0; i < N; i++) begin
        if ((int'(force_sel) == i) && req[i]) begin
          grant[i]  = 1'b1;
          grant_idx = SEL_W'(i);
          any_grant = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = (int'(ptr) + k) % N;
        if (!any_grant && req[idx]) begin
          grant[idx] = 1'b1;
          grant_idx  = SEL_W'(idx);
          any_grant  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mux_rr_stream.sv
// N-input registered stream mux, round-robin or forced select; MUX_RR_PKT_LOCK_EN adds packet lock.
// Latency: word accepted at edge k appears on out_valid/out_data right after edge k.
// Backpressure: in_ready only when the output slot is empty or draining this cycle; 1 word/cycle.
module mux_rr_stream
  import mux_rr_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int W     = W_DEF,
  parameter int SEL_W = clog2_min1(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_valid,
  input  logic [N*W-1:0]   in_data,
`ifdef MUX_RR_PKT_LOCK_EN
  input  logic [N-1:0]     in_last,
  output logic             out_last,
`endif
  output logic [N-1:0]     in_ready,
  input  logic             force_en,
  input  logic [SEL_W-1:0] force_sel,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_sel,
  input  logic             out_ready
);

  logic             r_out_valid;
  logic [W-1:0]     r_out_data;
  logic [SEL_W-1:0] r_out_sel;
  logic [SEL_W-1:0] r_rr_ptr;

  logic             w_free;
  logic             w_xfer;
  logic             w_adv_ptr;
  logic             w_force_en;
  logic [SEL_W-1:0] w_force_sel;
  logic [N-1:0]     w_grant;
  logic [SEL_W-1:0] w_grant_idx;
  logic             w_any_grant;
  logic [W-1:0]     w_sel_data;
  logic [SEL_W-1:0] w_ptr_nxt;

`ifdef MUX_RR_PKT_LOCK_EN
  logic             r_lock;
  logic [SEL_W-1:0] r_lock_idx;
  logic             r_lock_rr;
  logic             r_out_last;
  logic             w_sel_last;

  // While a packet is open the arbiter is pinned to its owner and force_en is ignored.
  assign w_force_en  = r_lock ? 1'b1 : force_en;
  assign w_force_sel = r_lock ? r_lock_idx : force_sel;
  // Pointer moves only when the last word of a round-robin packet goes through.
  assign w_adv_ptr   = w_xfer && w_sel_last && (r_lock ? r_lock_rr : !force_en);
  assign out_last    = r_out_last;
`else
  assign w_force_en  = force_en;
  assign w_force_sel = force_sel;
  assign w_adv_ptr   = w_xfer && !force_en;
`endif

  rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .req       (in_valid),
    .ptr       (r_rr_ptr),
    .force_en  (w_force_en),
    .force_sel (w_force_sel),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .any_grant (w_any_grant)
  );

  assign w_free   = !r_out_valid || out_ready;
  assign w_xfer   = w_any_grant && w_free;
  assign in_ready = rst_n ? (w_grant & {N{w_free}}) : '0;

  assign w_ptr_nxt = (int'(w_grant_idx) >= N - 1) ? '0 : SEL_W'(w_grant_idx + 1'b1);

  // One-hot grant steers the winning channel's data (and last flag) to the register input.
  always_comb begin
    w_sel_data = '0;
`ifdef MUX_RR_PKT_LOCK_EN
    w_sel_last = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      w_sel_data = w_sel_data | (in_data[i*W +: W] & {W{w_grant[i]}});
`ifdef MUX_RR_PKT_LOCK_EN
      w_sel_last = w_sel_last | (in_last[i] & w_grant[i]);
`endif
    end
  end

  // Output register: load on transfer, clear valid on a plain drain, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_sel   <= w_grant_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Round-robin pointer: next search starts just past the last round-robin winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_adv_ptr) begin
      r_rr_ptr <= w_ptr_nxt;
    end
  end

`ifdef MUX_RR_PKT_LOCK_EN
  // Packet lock: opened by a non-last word, closed by the owner's last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_lock_rr  <= 1'b0;
      r_out_last <= 1'b0;
    end else if (w_xfer) begin
      r_out_last <= w_sel_last;
      if (w_sel_last) begin
        r_lock <= 1'b0;
      end else begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_grant_idx;
        if (!r_lock) begin
          r_lock_rr <= !force_en;
        end
      end
    end
  end
`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux_rr_stream.sv
// Directed bench for mux_rr_stream: expected words queued at issue, checked by a monitor.
// Latency: monitor checks the word held on the output whenever out_valid && out_ready.
// Backpressure: exercised by holding out_ready low with requests pending.
module tb_mux_rr_stream;

  localparam int N = 4;
  localparam int W = 8;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           force_en;
  logic [S-1:0]   force_sel;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [S-1:0]   out_sel;
  logic           out_ready;

  // Second instance with N=5 so an out-of-range force_sel (5) is expressible.
  logic [4:0]     in_valid5;
  logic [39:0]    in_data5;
  logic [4:0]     in_ready5;
  logic           force_en5;
  logic [2:0]     force_sel5;
  logic           out_valid5;
  logic [7:0]     out_data5;
  logic [2:0]     out_sel5;
  logic           out_ready5;

`ifdef MUX_RR_PKT_LOCK_EN
  logic [N-1:0]   in_last  = '1;
  logic           out_last;
  logic [4:0]     in_last5 = '1;
  logic           out_last5;
`endif

  always #5 clk = ~clk;

  mux_rr_stream #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef MUX_RR_PKT_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .in_ready  (in_ready),
    .force_en  (force_en),
    .force_sel (force_sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  mux_rr_stream #(.N(5), .W(8)) dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid5),
    .in_data   (in_data5),
`ifdef MUX_RR_PKT_LOCK_EN
    .in_last   (in_last5),
    .out_last  (out_last5),
`endif
    .in_ready  (in_ready5),
    .force_en  (force_en5),
    .force_sel (force_sel5),
    .out_valid (out_valid5),
    .out_data  (out_data5),
    .out_sel   (out_sel5),
    .out_ready (out_ready5)
  );

  typedef struct {
    logic [W-1:0] d;
    logic [S-1:0] s;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] d, input logic [S-1:0] s);
    exp_t e;
    e.d = d;
    e.s = s;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, q.size(), 0);
  endtask

  // Monitor: a handshake seen at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_word: got data=0x%0h sel=%0d expected none", out_data, out_sel);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (out_data !== e.d || out_sel !== e.s) begin
          failures++;
          $display("FAIL word: got data=0x%0h sel=%0d expected data=0x%0h sel=%0d",
                   out_data, out_sel, e.d, e.s);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    in_valid   = '1;
    in_data    = 32'h44332211;
    out_ready  = 1'b0;
    force_en   = 1'b0;
    force_sel  = '0;
    in_valid5  = '0;
    in_data5   = 40'h5544332211;
    force_en5  = 1'b0;
    force_sel5 = '0;
    out_ready5 = 1'b1;

    // Reset state with every channel requesting.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_out_sel",   out_sel,   0);
    chk("rst_in_ready",  in_ready,  0);

    step();
    in_valid = '0;
    rst_n    = 1'b1;
    step();

    // Round-robin fairness: all valid, full throughput.
    in_valid  = '1;
    out_ready = 1'b1;
    #1;
    chk("first_grant_ch0", in_ready, 4'b0001);
    push(8'h11, 0); push(8'h22, 1); push(8'h33, 2); push(8'h44, 3); push(8'h11, 0);
    repeat (5) step();
    in_valid = '0;
    wait_empty("rr_drain");

    // Sparse requests and wrap (pointer now 1).
    step();
    in_data  = 32'hD4C3B2A1;
    in_valid = 4'b0100;
    push(8'hC3, 2);
    step();
    in_valid = 4'b0010;
    #1;
    chk("ptr3_only_ch1", in_ready, 4'b0010);
    push(8'hB2, 1);
    step();
    in_valid = 4'b0101;
    #1;
    chk("ch0_ch2_picks_ch2", in_ready, 4'b0100);
    push(8'hC3, 2); push(8'hA1, 0);
    step();
    step();
    in_valid = '0;
    wait_empty("sparse_drain");

    // Backpressure (pointer now 1).
    step();
    in_data   = 32'h00A50000;
    in_valid  = 4'b0100;
    out_ready = 1'b0;
    push(8'hA5, 2);
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid",    out_valid, 1);
      chk("stall_data",     out_data,  8'hA5);
      chk("stall_in_ready", in_ready,  0);
    end
    step();
    out_ready = 1'b1;
    in_valid  = '0;
    step();
    @(negedge clk);
    chk("drain_1cycle", out_valid, 0);
    wait_empty("bp_drain");

    // Forced mode (pointer now 3): only ch2, pointer untouched.
    step();
    in_data   = 32'h44332211;
    in_valid  = '1;
    force_en  = 1'b1;
    force_sel = 2'd2;
    #1;
    chk("force_ready_ch2", in_ready, 4'b0100);
    push(8'h33, 2); push(8'h33, 2); push(8'h33, 2);
    repeat (3) step();
    force_en = 1'b0;
    #1;
    chk("ptr_kept_ch3", in_ready, 4'b1000);
    push(8'h44, 3);
    step();
    in_valid = '0;
    wait_empty("force_drain");

    // Out-of-range forced index on the 5-channel instance.
    in_valid5  = '1;
    force_en5  = 1'b1;
    force_sel5 = 3'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("sel5_no_ready", in_ready5,  0);
      chk("sel5_no_valid", out_valid5, 0);
    end
    step();
    force_sel5 = 3'd4;
    #1;
    chk("sel4_ready", in_ready5, 5'b10000);
    step();
    in_valid5 = '0;
    @(negedge clk);
    chk("sel4_out", {out_valid5, out_sel5, out_data5}, {1'b1, 3'd4, 8'h55});

    // Reset mid-operation with a held word.
    step();
    in_data   = 32'h00007E00;
    in_valid  = 4'b0010;
    out_ready = 1'b0;
    step();
    in_valid = '0;
    @(negedge clk);
    chk("held_before_rst", {out_valid, out_data}, {1'b1, 8'h7E});
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data",  out_data,  0);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_data   = 32'h44332211;
    in_valid  = '1;
    #1;
    chk("ptr_reset_ch0", in_ready, 4'b0001);
    push(8'h11, 0);
    step();
    in_valid = '0;
    wait_empty("final_drain");
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
